// File: rtl/mult_modp_iter.sv
// Digit-serial modular multiplier: prod = (x * y) mod (2^N - C).
// MSB-first Horner loop consuming D bits of y per cycle.
module mult_modp_iter #(
  parameter int N = 255,
  parameter int C = 19,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic [N-1:0] prod,
  output logic         data_rdy
);

  localparam int ITERS = (N + D - 1) / D;
  localparam int YW    = ITERS * D;
  localparam int W     = N + D + 2;
  localparam int CNTW  = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [N-1:0] P  = {N{1'b1}} - N'(C - 1);
  localparam logic [N:0]   P1 = {1'b0, P};
  localparam logic [W-1:0] CW = W'(C);
  localparam logic [N:0]   C1 = (N+1)'(C);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    NORM
  } state_t;

  state_t          state;
  logic [N-1:0]    xr;
  logic [YW-1:0]   yr;
  logic [N:0]      acc;
  logic [CNTW-1:0] cnt;

  logic [D-1:0]    digit;
  logic [N+D-1:0]  pp;
  logic [W-1:0]    sum;
  logic [N:0]      f1;
  logic [N:0]      acc_nxt;

  // Fold bits >= N back in as hi*C; a second 1-bit fold keeps acc < 2^N.
  always_comb begin
    digit   = yr[YW-1 -: D];
    pp      = (N+D)'(xr) * (N+D)'(digit);
    sum     = (W'(acc) << D) + W'(pp);
    f1      = (N+1)'(W'(sum[W-1:N]) * CW + W'(sum[N-1:0]));
    acc_nxt = {1'b0, f1[N-1:0]} + (f1[N] ? C1 : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      data_rdy <= 1'b0;
      prod     <= '0;
      xr       <= '0;
      yr       <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xr       <= x;
            yr       <= YW'(y);
            data_rdy <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xr >= P) xr <= xr - P;
          acc   <= '0;
          cnt   <= CNTW'(ITERS - 1);
          state <= ITER;
        end
        ITER: begin
          acc <= acc_nxt;
          yr  <= yr << D;
          cnt <= cnt - CNTW'(1);
          if (cnt == '0) state <= NORM;
        end
        NORM: begin
          prod     <= N'((acc >= P1) ? acc - P1 : acc);
          data_rdy <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_modp_iter.sv
// Bench for mult_modp_iter: D=4, D=1 and D=8 instances
// checked against a bignum (x*y) % p reference.
module tb_mult_modp_iter;

  localparam int N = 255;
  localparam int C = 19;
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] P    = ONES - N'(C) + N'(1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        start_v;
  logic [N-1:0]      x;
  logic [N-1:0]      y;
  logic [2:0]        busy_v;
  logic [2:0]        rdy_v;
  logic [2:0][N-1:0] prod_v;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_modp_iter #(.N(N), .C(C), .D(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(x), .y(y),
    .busy(busy_v[0]), .prod(prod_v[0]), .data_rdy(rdy_v[0])
  );

  mult_modp_iter #(.N(N), .C(C), .D(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(x), .y(y),
    .busy(busy_v[1]), .prod(prod_v[1]), .data_rdy(rdy_v[1])
  );

  mult_modp_iter #(.N(N), .C(C), .D(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .x(x), .y(y),
    .busy(busy_v[2]), .prod(prod_v[2]), .data_rdy(rdy_v[2])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 66 : (i == 1) ? 257 : 34;
  endfunction

  function automatic int dv(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [2*N-1:0] pr;
    logic [2*N-1:0] md;
    pr = (2*N)'(a) * (2*N)'(b);
    md = (2*N)'(P);
    return N'(pr % md);
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [255:0] t = '0;
    for (int k = 0; k < 8; k++) t = {t[223:0], $urandom()};
    case ($urandom_range(0, 7))
      0:       return P + N'($urandom_range(0, 18));
      1:       return ONES - N'($urandom_range(0, 40));
      default: return N'(t);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch on the instances in m, optionally re-pulse start at cycle inj,
  // then check result timing and value on each.
  task automatic op(input logic [2:0] m, input logic [N-1:0] xv,
                    input logic [N-1:0] yv, input logic [N-1:0] exp,
                    input int inj, input string tag);
    int  first_rdy[3];
    int  first_idle[3];
    bit  done;
    first_rdy  = '{0, 0, 0};
    first_idle = '{0, 0, 0};
    @(negedge clk);
    x       = xv;
    y       = yv;
    start_v = m;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (m[i]) begin
      chk($sformatf("%s_busy_t0_d%0d", tag, dv(i)), N'(busy_v[i]), N'(1));
      chk($sformatf("%s_rdy_t0_d%0d", tag, dv(i)), N'(rdy_v[i]), N'(0));
    end
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start_v = (k == inj) ? m : 3'b000;
      if (k == inj) begin
        x = ~xv;
        y = xv ^ yv;
      end
      @(posedge clk); #1;
      done = 1'b1;
      for (int i = 0; i < 3; i++) if (m[i]) begin
        if (first_rdy[i] == 0 && rdy_v[i]) first_rdy[i] = k;
        if (first_idle[i] == 0 && !busy_v[i]) first_idle[i] = k;
        if (first_rdy[i] == 0) done = 1'b0;
      end
      if (done) break;
    end
    start_v = '0;
    for (int i = 0; i < 3; i++) if (m[i]) begin
      chk($sformatf("%s_rdy_lat_d%0d", tag, dv(i)),
          N'(first_rdy[i]), N'(lat(i)));
      chk($sformatf("%s_busy_lat_d%0d", tag, dv(i)),
          N'(first_idle[i]), N'(lat(i)));
      chk($sformatf("%s_prod_d%0d", tag, dv(i)), prod_v[i], exp);
    end
  endtask

  initial begin
    logic [N-1:0] t254;
    logic [N-1:0] a;
    logic [N-1:0] b;

    rst_n   = 1'b0;
    start_v = '0;
    x       = '0;
    y       = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy_d%0d", dv(i)), N'(busy_v[i]), N'(0));
      chk($sformatf("rst_rdy_d%0d", dv(i)), N'(rdy_v[i]), N'(0));
      chk($sformatf("rst_prod_d%0d", dv(i)), prod_v[i], N'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    op(3'b111, N'(5), N'(12), N'(60), 0, "x5y12");
    repeat (100) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_prod_d%0d", dv(i)), prod_v[i], N'(60));
      chk($sformatf("hold_rdy_d%0d", dv(i)), N'(rdy_v[i]), N'(1));
      chk($sformatf("hold_busy_d%0d", dv(i)), N'(busy_v[i]), N'(0));
    end

    t254      = '0;
    t254[254] = 1'b1;
    op(3'b111, ONES, ONES, N'(324), 0, "ones");
    op(3'b111, P - N'(1), P - N'(1), N'(1), 0, "pm1");
    op(3'b111, ONES, N'(0), N'(0), 0, "y_zero");
    op(3'b111, N'(0), ONES, N'(0), 0, "x_zero");
    op(3'b111, P, N'(5), N'(0), 0, "x_is_p");
    op(3'b111, t254, N'(2), N'(19), 0, "wrap254");
    op(3'b111, N'(5), N'(12), N'(60), 10, "restart_ign");

    @(negedge clk);
    x       = N'(3);
    y       = N'(4);
    start_v = 3'b111;
    @(posedge clk); #1;
    start_v = '0;
    repeat (29) @(posedge clk);
    #3;
    for (int i = 0; i < 3; i++)
      chk($sformatf("pre_abort_busy_d%0d", dv(i)), N'(busy_v[i]), N'(1));
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_busy_d%0d", dv(i)), N'(busy_v[i]), N'(0));
      chk($sformatf("abort_rdy_d%0d", dv(i)), N'(rdy_v[i]), N'(0));
      chk($sformatf("abort_prod_d%0d", dv(i)), prod_v[i], N'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(3'b111, N'(7), N'(9), N'(63), 0, "after_rst");

    for (int r = 0; r < 400; r++) begin
      a = rnd();
      b = rnd();
      op(3'b101, a, b, ref_mul(a, b), 0, "rnd48");
    end
    for (int r = 0; r < 600; r++) begin
      a = rnd();
      b = rnd();
      op(3'b100, a, b, ref_mul(a, b), 0, "rnd8");
    end
    for (int r = 0; r < 40; r++) begin
      a = rnd();
      b = rnd();
      op(3'b010, a, b, ref_mul(a, b), 0, "rnd1");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_modp_iter.md
Name: mult_modp_iter

Overview:
- Iterative digit-serial multiplier computing prod = (x * y) mod p, with p = 2^N - C (default p = 2^255 - 19).
- Next-generation replacement for the fixed 255-bit modular multiplier in the field-arithmetic datapath.
- Adds an explicit start/busy handshake in place of reset-triggered operation.
- Adds parametrised modulus and digit width (D multiplier bits consumed per cycle), so area and latency can be traded.
- Guarantees a fully reduced result in [0, p) for any N-bit inputs, including inputs >= p.

Parameters:
- N, 255, operand/result width; modulus is 2^N - C.
- C, 19, modulus offset; legal range 1 <= C < 2^(N/2), C odd.
- D, 4, multiplier digit width (bits of y per iteration); legal 1..16.
- ITERS (localparam), ceil(N/D), iteration count; y is zero-extended to ITERS*D bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk when busy=0.
- x  input  N  multiplicand; any value 0..2^N-1.
- y  input  N  multiplier; any value 0..2^N-1.
- busy  output  1  high while an operation is in progress.
- prod  output  N  result, fully reduced, in [0, p).
- data_rdy  output  1  level; high while prod holds a valid result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; data_rdy=0; prod=0; all internal registers cleared. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, LOAD, ITER, NORM.
- IDLE:
  - Waits for start=1. On that edge, capture x and y into internal registers, clear data_rdy, set busy, go to LOAD.
  - x and y are ignored outside the capture edge.
- LOAD (1 cycle):
  - xr = x mod p, computed by one conditional subtract (x >= p implies x - p < p).
  - acc = 0; digit counter = ITERS-1; go to ITER.
- ITER (ITERS cycles), MSB-first Horner step:
  - acc <= (acc * 2^D + xr * y_digit) mod p, where y_digit is the counter-selected D-bit slice of zero-extended y.
  - Reduction folds bits at and above N: hi * C + lo, repeated until the value fits in N+1 bits.
  - acc must be < 2p at the end of every step.
  - After the step with counter=0, go to NORM.
- NORM (1 cycle):
  - prod <= (acc >= p) ? acc - p : acc.
  - data_rdy <= 1; busy <= 0; go to IDLE.
- Latency:
  - start is accepted at edge t0; busy=1 from t0.
  - prod is valid and data_rdy=1 from edge t0 + ITERS + 2.
  - Default ITERS=64, so latency is 66 cycles. For D=1, latency is 257 cycles.
- start while busy=1: ignored; no queuing; the running operation is unaffected.
- start in the same cycle that data_rdy rises: not possible, because busy is still 1 in that cycle.
- Back-to-back operation: start may be asserted on the first cycle busy=0.
- Result hold: prod and data_rdy hold until the next accepted start (data_rdy then drops) or reset.
- Widths: no truncation of intermediates before reduction. Internal sums are sized for (2p) * 2^D + p * (2^D - 1).

Test Plan:
- Reset, then start with x=5, y=12 -> busy=1 for 66 cycles; data_rdy rises at t0+66; prod=60 (0x3c); prod holds for 100 idle cycles.
- x=2^255-1, y=2^255-1 (inputs >= p, each reduces to 18) -> prod=324. Then x=p-1, y=p-1 -> prod=1.
- Zero and wrap cases:
  - x=all-ones, y=0 -> prod=0.
  - x=0, y=all-ones -> prod=0.
  - x=p, y=5 -> prod=0.
  - x=2^254, y=2 -> prod=19.
- Reassert start at t0+10 with new operands during the x=5, y=12 operation -> ignored; prod=60 at t0+66 unchanged.
- Pull rst_n low at t0+30 during an operation -> busy, data_rdy and prod go to 0 immediately. Then a new start with x=7, y=9 -> prod=63.
- Re-run the suite with D=1 and D=8 -> identical results; latency 257 and 34 cycles respectively. Add 1000 random x,y pairs checked against a bignum reference model.
